// File: rtl/hba_pkg.sv
// Shared HBA bus definitions: default bus widths, arbiter state encoding and
// a width helper used for pointer and counter sizing.
package hba_pkg;

  localparam int unsigned HbaDbusWidth       = 8;
  localparam int unsigned HbaPeriphAddrWidth = 4;
  localparam int unsigned HbaRegAddrWidth    = 8;
  localparam int unsigned HbaAddrWidth       = HbaPeriphAddrWidth + HbaRegAddrWidth;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } hba_state_e;

  // max(1, clog2(n)): keeps single-entry pointers/counters at one bit.
  function automatic int unsigned hba_width_for(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational round-robin priority encoder: first requester strictly after
// the pointer, searching upward with wrap.
module hba_rr_pick
  import hba_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned PtrW   = hba_width_for(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PtrW-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    int unsigned pos;
    pos     = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan farthest offset first so the nearest requester is written last.
    for (int unsigned k = NumReq; k >= 1; k--) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NumReq) begin
        pos = pos - NumReq;
      end
      if (req_i[pos[PtrW-1:0]]) begin
        gnt_o                = '0;
        gnt_o[pos[PtrW-1:0]] = 1'b1;
        idx_o                = pos[PtrW-1:0];
        valid_o              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hba_arbiter.sv
// HBA multi-master arbiter: round-robin, non-preemptive grants with a
// mandatory idle turnaround, optional grant watchdog and shared-bus OR.
module hba_arbiter
  import hba_pkg::*;
#(
  parameter int unsigned NUM_MASTERS      = 2,
  parameter int unsigned DBUS_WIDTH       = HbaDbusWidth,
  parameter int unsigned ADDR_WIDTH       = HbaAddrWidth,
  parameter int unsigned MAX_GRANT_CYCLES = 0
) (
  input  logic                              hba_clk,
  input  logic                              hba_reset,
  input  logic [NUM_MASTERS-1:0]            master_request,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus,
  input  logic [NUM_MASTERS-1:0]            master_rnw,
  input  logic [NUM_MASTERS-1:0]            master_select,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus,
  output logic [NUM_MASTERS-1:0]            hba_mgrant,
  output logic [ADDR_WIDTH-1:0]             hba_abus,
  output logic                              hba_rnw,
  output logic                              hba_select,
  output logic [DBUS_WIDTH-1:0]             hba_dbus,
  output logic                              arb_timeout
);

  localparam int unsigned PtrW = hba_width_for(NUM_MASTERS);
  localparam int unsigned CntW = hba_width_for(MAX_GRANT_CYCLES + 1);
  localparam logic [PtrW-1:0] PtrRst = PtrW'(NUM_MASTERS - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_GRANT_CYCLES);

  hba_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [PtrW-1:0]        pick_idx;
  logic                   pick_valid;
  logic                   g_req, g_sel, wd_hit;

  hba_rr_pick #(
    .NumReq (NUM_MASTERS),
    .PtrW   (PtrW)
  ) u_pick (
    .req_i   (master_request),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign g_req  = |(master_request & grant_q);
  assign g_sel  = |(master_select & grant_q);
  // Counter holds cycles already spent in grant; expiry on the last allowed one.
  assign wd_hit = (MAX_GRANT_CYCLES != 0) && (cnt_q >= CntW'(MAX_GRANT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          grant_d = pick_gnt;
          ptr_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (!g_req && !g_sel) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (wd_hit && !g_sel) begin
          state_d   = StIdle;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge hba_clk) begin
    if (!hba_reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= PtrRst;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    hba_abus   = '0;
    hba_rnw    = 1'b0;
    hba_select = 1'b0;
    hba_dbus   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      hba_abus   = hba_abus | (master_abus[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
      hba_rnw    = hba_rnw | (master_rnw[i] & grant_q[i]);
      hba_select = hba_select | (master_select[i] & grant_q[i]);
      hba_dbus   = hba_dbus | (master_dbus[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{grant_q[i]}});
    end
  end

  assign hba_mgrant  = grant_q;
  assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_hba_arbiter.sv
// Bench for hba_arbiter: one instance without watchdog, one with a 4-cycle
// watchdog, both driven by the same stimulus and tracked by a reference model.
module tb_hba_arbiter;

  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int WD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req, rnw, sel;
  logic [N*AW-1:0] abus;
  logic [N*DW-1:0] dbus;

  logic [N-1:0]  mg   [2];
  logic [AW-1:0] oab  [2];
  logic          ornw [2];
  logic          osel [2];
  logic [DW-1:0] odb  [2];
  logic          oto  [2];

  int nvec  = 0;
  int nfail = 0;

  // Reference model: granted master index (-1 none), last winner, cycles in grant.
  int mgr  [2];
  int mptr [2];
  int mcnt [2];
  bit mto  [2];
  int maxc [2] = '{0, WD};

  hba_arbiter #(
    .NUM_MASTERS(N), .DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_GRANT_CYCLES(0)
  ) u_dut0 (
    .hba_clk(clk), .hba_reset(rst_n), .master_request(req), .master_abus(abus),
    .master_rnw(rnw), .master_select(sel), .master_dbus(dbus), .hba_mgrant(mg[0]),
    .hba_abus(oab[0]), .hba_rnw(ornw[0]), .hba_select(osel[0]), .hba_dbus(odb[0]),
    .arb_timeout(oto[0])
  );

  hba_arbiter #(
    .NUM_MASTERS(N), .DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_GRANT_CYCLES(WD)
  ) u_dut1 (
    .hba_clk(clk), .hba_reset(rst_n), .master_request(req), .master_abus(abus),
    .master_rnw(rnw), .master_select(sel), .master_dbus(dbus), .hba_mgrant(mg[1]),
    .hba_abus(oab[1]), .hba_rnw(ornw[1]), .hba_select(osel[1]), .hba_dbus(odb[1]),
    .arb_timeout(oto[1])
  );

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit to_n;
      to_n = 1'b0;
      if (!rst_n) begin
        mgr[m]  = -1;
        mptr[m] = N - 1;
        mcnt[m] = 0;
      end else if (mgr[m] < 0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (mptr[m] + k) % N;
          if (mgr[m] < 0 && req[idx]) begin
            mgr[m]  = idx;
            mcnt[m] = 0;
          end
        end
        if (mgr[m] >= 0) mptr[m] = mgr[m];
      end else begin
        int gi;
        gi = mgr[m];
        if (!req[gi] && !sel[gi]) begin
          mgr[m] = -1;
        end else if (maxc[m] > 0 && mcnt[m] + 1 >= maxc[m] && !sel[gi]) begin
          mgr[m] = -1;
          to_n   = 1'b1;
        end else begin
          mcnt[m]++;
        end
      end
      mto[m] = to_n;
    end
  endtask

  function automatic logic [N-1:0] exp_g(int m);
    logic [N-1:0] r;
    r = '0;
    if (mgr[m] >= 0) r[mgr[m]] = 1'b1;
    return r;
  endfunction

  function automatic logic [AW+DW+1:0] exp_bus(int m);
    if (mgr[m] < 0) return '0;
    return {abus[mgr[m]*AW +: AW], rnw[mgr[m]], sel[mgr[m]], dbus[mgr[m]*DW +: DW]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = '0; sel = '0; rnw = '0; abus = '0; dbus = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '1; sel = '1; rnw = '1; abus = '1; dbus = '1;
    repeat (3) begin
      cycle();
      for (int m = 0; m < 2; m++) begin
        nvec++;
        if (mg[m] !== '0 || oto[m] !== 1'b0) begin
          nfail++;
          $display("FAIL reset_grant[%0d]: got %b/%b want 00/0", m, mg[m], oto[m]);
        end
        nvec++;
        if ({oab[m], ornw[m], osel[m], odb[m]} !== '0) begin
          nfail++;
          $display("FAIL reset_bus[%0d]: got %h/%b/%b/%h want 0", m, oab[m], ornw[m], osel[m],
                   odb[m]);
        end
      end
    end
    rst_n = 1'b1;
    cycle();
    for (int m = 0; m < 2; m++) begin
      nvec++;
      if (mg[m] !== 2'b01) begin
        nfail++;
        $display("FAIL reset_first_grant[%0d]: got %b want 01", m, mg[m]);
      end
    end
    idle_inputs();
    repeat (2) cycle();
  endtask

  task automatic test_single();
    req = 2'b10;
    cycle();
    sel  = 2'b11;
    rnw  = 2'b01;
    abus = {12'h005, 12'hFFF};
    dbus = {8'hA5, 8'hFF};
    #1;
    for (int m = 0; m < 2; m++) begin
      nvec++;
      if (mg[m] !== 2'b10) begin
        nfail++;
        $display("FAIL single_grant[%0d]: got %b want 10", m, mg[m]);
      end
      nvec++;
      if ({oab[m], ornw[m], osel[m], odb[m]} !== {12'h005, 1'b0, 1'b1, 8'hA5}) begin
        nfail++;
        $display("FAIL single_bus[%0d]: got %h/%b/%b/%h want 005/0/1/a5", m, oab[m], ornw[m],
                 osel[m], odb[m]);
      end
    end
    req = 2'b00;
    sel = 2'b01;
    cycle();
    for (int m = 0; m < 2; m++) begin
      nvec++;
      if (mg[m] !== 2'b00 || {oab[m], ornw[m], osel[m], odb[m]} !== '0) begin
        nfail++;
        $display("FAIL single_release[%0d]: got grant %b abus %h dbus %h want 00/0/0", m, mg[m],
                 oab[m], odb[m]);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [9];
    int held;
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    held = 0;
    req = 2'b11;
    for (int i = 0; i < 9; i++) begin
      cycle();
      for (int m = 0; m < 2; m++) begin
        nvec++;
        if (mg[m] !== exp_seq[i]) begin
          nfail++;
          $display("FAIL rr_seq[%0d] step %0d: got %b want %b", m, i, mg[m], exp_seq[i]);
        end
      end
      held = (mgr[0] >= 0) ? held + 1 : 0;
      req = 2'b11;
      if (held == 3) req[mgr[0]] = 1'b0;
    end
    idle_inputs();
    repeat (2) cycle();
  endtask

  task automatic test_no_preempt();
    req = 2'b01;
    cycle();
    req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      cycle();
      nvec++;
      if (mg[0] !== 2'b01) begin
        nfail++;
        $display("FAIL no_preempt cyc %0d: got %b want 01", i, mg[0]);
      end
    end
    idle_inputs();
    repeat (4) cycle();
  endtask

  task automatic test_early_drop();
    logic [N-1:0] want;
    req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cycle();
      want = (i < 4) ? 2'b01 : 2'b00;
      for (int m = 0; m < 2; m++) begin
        nvec++;
        if (mg[m] !== want || oto[m] !== 1'b0) begin
          nfail++;
          $display("FAIL early_drop[%0d] step %0d: got %b/%b want %b/0", m, i, mg[m], oto[m],
                   want);
        end
      end
      sel = (i < 3) ? 2'b01 : 2'b00;
      if (i >= 1) req = 2'b00;
    end
    idle_inputs();
    repeat (2) cycle();
  endtask

  task automatic test_watchdog();
    logic [N-1:0] want_g;
    logic         want_t;
    req = 2'b01;
    for (int i = 0; i < 6; i++) begin
      cycle();
      want_g = (i < 4) ? 2'b01 : (i == 4) ? 2'b00 : 2'b10;
      want_t = (i == 4);
      nvec++;
      if (mg[1] !== want_g || oto[1] !== want_t) begin
        nfail++;
        $display("FAIL watchdog step %0d: got grant %b timeout %b want %b %b", i, mg[1], oto[1],
                 want_g, want_t);
      end
      req = 2'b11;
    end
    idle_inputs();
    repeat (4) cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int b = 0; b < N; b++) begin
        req[b] = ($urandom_range(0, 9) < 7);
        sel[b] = ($urandom_range(0, 3) == 0);
      end
      rnw  = N'($urandom);
      abus = (N*AW)'($urandom);
      dbus = (N*DW)'($urandom);
      cycle();
      for (int m = 0; m < 2; m++) begin
        nvec++;
        if (mg[m] !== exp_g(m)) begin
          nfail++;
          $display("FAIL rand_grant[%0d] cyc %0d: got %b want %b", m, i, mg[m], exp_g(m));
        end
        nvec++;
        if ({oab[m], ornw[m], osel[m], odb[m]} !== exp_bus(m)) begin
          nfail++;
          $display("FAIL rand_bus[%0d] cyc %0d: got %h want %h", m, i,
                   {oab[m], ornw[m], osel[m], odb[m]}, exp_bus(m));
        end
        nvec++;
        if (oto[m] !== mto[m]) begin
          nfail++;
          $display("FAIL rand_timeout[%0d] cyc %0d: got %b want %b", m, i, oto[m], mto[m]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mgr[m] = -1; mptr[m] = N - 1; mcnt[m] = 0; mto[m] = 1'b0;
    end
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_early_drop();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/hba_arbiter.md
Name: hba_arbiter

Overview:
- Multi-master arbiter and bus combiner for the HBA bus.
- Sits between N HBA bus masters (serial_fpga and future masters) and the shared slave bus (hba_reg_bank and other peripherals).
- Implements the master_request/hba_mgrant handshake with round-robin fairness, non-preemptive grants and an optional grant watchdog.
- ORs the granted master's abus/rnw/select/dbus onto the shared bus.

Parameters:
- NUM_MASTERS, 2, number of masters; legal range 1..8.
- DBUS_WIDTH, 8, data bus width.
- ADDR_WIDTH, 12, address bus width (PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH).
- MAX_GRANT_CYCLES, 0, watchdog limit on cycles per grant; 0 disables the watchdog.

Ports:
- hba_clk  in  1  bus clock; all logic on the rising edge.
- hba_reset  in  1  synchronous, active-low reset (0 = reset).
- master_request  in  NUM_MASTERS  per-master bus request.
- master_abus  in  NUM_MASTERS*ADDR_WIDTH  concatenated master addresses; master i occupies slice i.
- master_rnw  in  NUM_MASTERS  per-master read-not-write.
- master_select  in  NUM_MASTERS  per-master transfer in progress.
- master_dbus  in  NUM_MASTERS*DBUS_WIDTH  concatenated master write data.
- hba_mgrant  out  NUM_MASTERS  one-hot grant, registered.
- hba_abus  out  ADDR_WIDTH  shared address bus.
- hba_rnw  out  1  shared rnw.
- hba_select  out  1  shared select.
- hba_dbus  out  DBUS_WIDTH  shared write data.
- arb_timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (hba_reset == 0 at a clock edge):
  - State = IDLE, hba_mgrant = 0, arb_timeout = 0.
  - RR pointer = NUM_MASTERS-1, so master 0 has first priority.
  - Grant counter = 0.
  - Shared bus outputs are 0, because no master is granted.
- Bus combining (combinational from the registered grant):
  - hba_abus = OR over i of (master_abus slice i AND {ADDR_WIDTH{hba_mgrant[i]}}).
  - hba_rnw, hba_select and hba_dbus are combined the same way.
  - With no grant, all shared outputs are 0, which meets the HBA "zero when inactive" rule.
- State IDLE:
  - If any request is set, pick the first requester searching from (pointer+1) mod NUM_MASTERS upward with wrap.
  - Set its hba_mgrant bit at the next edge, load the pointer with that index, clear the counter, go to GRANT.
  - Latency: request seen at edge t gives grant visible after edge t+1 (one cycle).
- State GRANT:
  - The grant is held and never preempted by other requests.
  - Release: when the granted master's request = 0 and its select = 0, clear hba_mgrant at the next edge and go to IDLE.
  - Request dropped while select = 1: hold the grant until select = 0 (the transfer completes).
  - Turnaround: at least one idle cycle with no grant always separates consecutive grants, even to the same master.
- Watchdog:
  - When MAX_GRANT_CYCLES > 0, the counter increments every cycle in GRANT.
  - When it reaches MAX_GRANT_CYCLES and the granted select = 0: clear the grant, pulse arb_timeout for one cycle, go to IDLE.
  - If select = 1 at expiry, defer the revocation until select = 0.
  - A revoked master still requesting competes normally and goes to the back of round-robin order.
- Simultaneous events:
  - A release and new requests in the same cycle still give IDLE for one cycle, then arbitration.
  - Requests arriving during GRANT are not latched; master_request is level-sensitive.
- Reset mid-operation: grant clears at that edge and shared outputs drop to 0 combinationally.
- NUM_MASTERS = 1: same FSM; the pointer is a constant 0.
- Widths:
  - Pointer width = max(1, clog2(NUM_MASTERS)).
  - Counter width = max(1, clog2(MAX_GRANT_CYCLES+1)).

Decomposition:
- Shared hba package holds the state encoding (IDLE, GRANT) and the HBA default widths (DBUS_WIDTH 8, PERIPH_ADDR_WIDTH 4, REG_ADDR_WIDTH 8).
- One sub-module: hba_rr_pick.
  - Combinational round-robin priority encoder.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, winner index, valid.
- hba_arbiter contains the FSM, counter and bus OR.

Test Plan:
- Reset hold: hba_reset = 0 with all requests = 1 gives hba_mgrant = 0 and all shared outputs 0. Releasing reset gives hba_mgrant = 2'b01 one cycle later.
- Single transfer: master 1 requests, then drives abus = 12'h005, rnw = 0, select = 1, dbus = 8'hA5.
  - Required: hba_mgrant = 2'b10.
  - Required: shared bus shows 12'h005 / 0 / 1 / 8'hA5, while master 0 garbage (abus 12'hFFF) is masked.
- Round-robin: both masters hold request continuously, each releasing after 3 cycles of grant.
  - Required grant sequence: 01, idle, 10, idle, 01, with exactly one zero-grant cycle between grants.
- No preemption: master 0 is granted, master 1 requests, master 0 keeps request for 10 cycles. Required: hba_mgrant stays 2'b01 for all 10 cycles.
- Early request drop: master 0 drops request while select = 1, with select falling 2 cycles later. Required: grant clears only on the edge after select = 0.
- Watchdog: MAX_GRANT_CYCLES = 4, master 0 holds request with select = 0.
  - Required: grant revoked after 4 grant cycles and arb_timeout high for exactly 1 cycle.
  - Required: master 1 (requesting) is granted after one idle cycle.
